// File: rtl/planta_pkg.sv
// planta_pkg: shared state encoding and temperature widths for the thermal plant
package planta_pkg;
  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    CALENTANDO = 2'd1,
    ENFRIANDO  = 2'd2,
    CONFLICTO  = 2'd3
  } modo_t;
  localparam int TW = 11;
  localparam int SW = 13;
endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: free-running 0..DIV-1 counter that pulses tick on its last count
module divisor_tick #(
  parameter int DIV = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    tick,
  output logic [$clog2(DIV)-1:0]  count
);
  localparam int CW = $clog2(DIV);
  // tick is decoded straight from the count so it lines up with count == DIV-1
  always_comb tick = count == CW'(DIV - 1);
  // wrap to zero on the tick cycle so the period is exactly DIV cycles
  always_ff @(posedge clk)
    if (rst || tick) count <= '0;
    else count <= count + 1'b1;
endmodule

// File: rtl/planta_termica.sv
// planta_termica: simple thermal plant model driven by heater/fan commands and disturbances
module planta_termica
  import planta_pkg::*;
#(
  parameter int DIV      = 100,
  parameter int T_AMB    = 250,
  parameter int T_MIN    = -400,
  parameter int T_MAX    = 1000,
  parameter int PASO_CAL = 2,
  parameter int PASO_VEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 calefactor,
  input  logic                 ventilador,
  input  logic                 pert_valid,
  input  logic signed [TW-1:0] pert_delta,
  output logic signed [TW-1:0] temp_salida,
  output logic                 tick,
  output logic [1:0]           modo,
  output logic                 saturado
);
  localparam logic signed [TW-1:0] AMB = TW'(T_AMB);
  localparam logic signed [SW-1:0] LO  = SW'(T_MIN);
  localparam logic signed [SW-1:0] HI  = SW'(T_MAX);
  modo_t state, nxt;
  logic signed [SW-1:0] step, sum, clamped;
  logic [$clog2(DIV)-1:0] unused_count;
  divisor_tick #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .count (unused_count)
  );
  // command bits map directly onto the state encoding: {fan, heater}
  always_comb nxt = modo_t'({ventilador, calefactor});
  // per-tick step from the registered state, then widened sum and clamp
  always_comb begin
    step = state == CALENTANDO ? SW'(PASO_CAL) :
           state == ENFRIANDO  ? -SW'(PASO_VEN) :
           state == REPOSO     ? (temp_salida < AMB ? SW'(1) : temp_salida > AMB ? -SW'(1) : '0) : '0;
    sum = SW'(temp_salida) + (tick ? step : '0) + (pert_valid ? SW'(pert_delta) : '0);
    clamped = sum < LO ? LO : sum > HI ? HI : sum;
  end
  // state tracks the commands every cycle; temperature and saturation move only on events
  always_ff @(posedge clk)
    if (rst) begin
      state       <= REPOSO;
      temp_salida <= AMB;
      saturado    <= 1'b0;
    end else begin
      state <= nxt;
      if (tick || pert_valid) begin
        temp_salida <= TW'(clamped);
        saturado    <= clamped == LO || clamped == HI;
      end
    end
  assign modo = state;
endmodule

// File: tb/tb_planta_termica.sv
// tb_planta_termica: directed checks of the thermal plant with DIV=4
module tb_planta_termica;
  logic clk = 1'b0;
  logic rst, calefactor, ventilador, pert_valid;
  logic signed [10:0] pert_delta, temp_salida;
  logic tick, saturado;
  logic [1:0] modo;
  int checks = 0;
  int failures = 0;

  planta_termica #(.DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .calefactor  (calefactor),
    .ventilador  (ventilador),
    .pert_valid  (pert_valid),
    .pert_delta  (pert_delta),
    .temp_salida (temp_salida),
    .tick        (tick),
    .modo        (modo),
    .saturado    (saturado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!tick && n < 8);
    chk("tick_seen", int'(tick), 1);
  endtask

  initial begin
    rst = 1'b1; calefactor = 1'b0; ventilador = 1'b0; pert_valid = 1'b0; pert_delta = '0;
    step(2);
    chk("rst_temp", int'(temp_salida), 250);
    chk("rst_modo", int'(modo), 0);
    chk("rst_sat", int'(saturado), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_count", int'(dut.u_div.count), 0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("idle_tick", int'(tick), (i % 4 == 3) ? 1 : 0);
      chk("idle_temp", int'(temp_salida), 250);
      chk("idle_modo", int'(modo), 0);
      step(1);
    end
    calefactor = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wait_tick();
      chk("heat_hold", int'(temp_salida), 250 + 2 * (k - 1));
      step(1);
      chk("heat_temp", int'(temp_salida), 250 + 2 * k);
      chk("heat_modo", int'(modo), 1);
    end
    ventilador = 1'b1;
    step(1);
    chk("conf_modo", int'(modo), 3);
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      step(1);
      chk("conf_temp", int'(temp_salida), 270);
    end
    pert_valid = 1'b1; pert_delta = 11'sd30;
    step(1);
    pert_valid = 1'b0;
    chk("pert_plus", int'(temp_salida), 300);
    pert_valid = 1'b1; pert_delta = 11'sd0;
    step(1);
    pert_valid = 1'b0;
    chk("pert_zero", int'(temp_salida), 300);
    chk("pre_rst_count", int'(dut.u_div.count), 2);
    rst = 1'b1; calefactor = 1'b0; ventilador = 1'b0; pert_valid = 1'b1; pert_delta = 11'sd100;
    step(1);
    pert_valid = 1'b0;
    chk("mid_rst_temp", int'(temp_salida), 250);
    chk("mid_rst_count", int'(dut.u_div.count), 0);
    chk("mid_rst_modo", int'(modo), 0);
    chk("mid_rst_tick", int'(tick), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rel_tick", int'(tick), (i == 3) ? 1 : 0);
      if (i < 3) step(1);
    end
    step(1);
    calefactor = 1'b1;
    wait_tick();
    pert_valid = 1'b1; pert_delta = 11'sd900;
    step(1);
    pert_valid = 1'b0; calefactor = 1'b0;
    chk("clamp_hi_temp", int'(temp_salida), 1000);
    chk("clamp_hi_sat", int'(saturado), 1);
    wait_tick();
    step(1);
    chk("drift_temp", int'(temp_salida), 999);
    chk("drift_sat", int'(saturado), 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0; pert_valid = 1'b1; pert_delta = -11'sd648;
    step(1);
    pert_valid = 1'b0; ventilador = 1'b1;
    chk("pert_neg", int'(temp_salida), -398);
    chk("pert_neg_sat", int'(saturado), 0);
    wait_tick();
    step(1);
    chk("clamp_lo_temp", int'(temp_salida), -400);
    chk("clamp_lo_sat", int'(saturado), 1);
    chk("cool_modo", int'(modo), 2);
    wait_tick();
    step(1);
    chk("lo_hold_temp", int'(temp_salida), -400);
    chk("lo_hold_sat", int'(saturado), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
